// File: rtl/rgb565_gray_sequencer.sv
// RGB565 pixel-pair to packed 8-bit grayscale sequencer.
// Input words (two RGB565 pixels) are buffered in a small FIFO, converted one
// pixel per cycle by a single shared converter, and packed four bytes per
// output word (oldest pixel in bits 7:0).
// Optional feature: define GRAY_FLUSH_EN to add a flush input that emits a
// partially filled output word (unfilled lanes zeroed) when the block is idle.
module rgb565_gray_sequencer #(
  parameter int unsigned INPUT_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic [31:0] inData,
  output logic        inReady,
  output logic        outValid,
  output logic [31:0] outData,
  input  logic        outReady,
  output logic        busy
`ifdef GRAY_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int unsigned AW = (INPUT_DEPTH > 1) ? $clog2(INPUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(INPUT_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     mem [INPUT_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [1:0]      lane;
  logic [31:0]     acc;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            converting;
  logic            stall;
  logic            conv_go;
  logic            out_take;
  logic [31:0]     head;
  logic [15:0]     pix;
  logic [16:0]     sum;
  logic [7:0]      y;

  // FIFO status, handshake qualifiers and conversion stall decision
  always_comb begin
    full       = (count == CW'(INPUT_DEPTH));
    empty      = (count == '0);
    push       = inValid && !full;
    converting = (state == LOW) || (state == HIGH);
    stall      = converting && (lane == 2'd3) && outValid && !outReady;
    conv_go    = converting && !stall;
    pop        = conv_go && (state == HIGH);
    out_take   = outValid && outReady;
    count_nxt  = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  assign inReady = !full;
  assign busy    = !empty || (state != IDLE) || (lane != 2'd0) || outValid;

  // Shared RGB565 -> 8-bit luma converter for the pixel selected by the FSM
  always_comb begin
    head = mem[rd_ptr];
    pix  = (state == HIGH) ? head[31:16] : head[15:0];
    sum  = 17'({pix[15:11], 3'b000}) * 17'd54
         + 17'({pix[10:5],  2'b00 }) * 17'd183
         + 17'({pix[4:0],   3'b000}) * 17'd19;
    y    = 8'(sum >> 8);
  end

`ifdef GRAY_FLUSH_EN
  logic        flush_req;
  logic        flush_ok;
  logic        flush_fire;
  logic [31:0] flush_word;

  // Flush is only meaningful with a partial word and nothing left to convert
  always_comb begin
    flush_ok   = (state == IDLE) && empty && !push && (lane != 2'd0);
    flush_fire = (flush || flush_req) && flush_ok && (!outValid || outReady);
    case (lane)
      2'd1:    flush_word = {24'h0, acc[7:0]};
      2'd2:    flush_word = {16'h0, acc[15:0]};
      2'd3:    flush_word = {8'h0,  acc[23:0]};
      default: flush_word = 32'h0;
    endcase
  end

  // Remember a flush request until the output register frees up
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_req <= 1'b0;
    end else begin
      flush_req <= flush_ok && (flush || flush_req) && !flush_fire;
    end
  end
`endif

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= inData;
    end
  end

  // FSM, FIFO pointers, lane accumulator and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane     <= 2'd0;
      acc      <= 32'h0;
      outValid <= 1'b0;
      outData  <= 32'h0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;

      case (state)
        IDLE: begin
          if (count_nxt != '0) begin
            state <= LOW;
          end
        end
        LOW: begin
          if (conv_go) begin
            state <= HIGH;
          end
        end
        HIGH: begin
          if (conv_go) begin
            state <= (count_nxt != '0) ? LOW : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (conv_go) begin
        acc[{lane, 3'b000} +: 8] <= y;
        lane                     <= lane + 2'd1;
      end

      if (conv_go && (lane == 2'd3)) begin
        outData  <= {y, acc[23:0]};
        outValid <= 1'b1;
`ifdef GRAY_FLUSH_EN
      end else if (flush_fire) begin
        outData  <= flush_word;
        outValid <= 1'b1;
        lane     <= 2'd0;
`endif
      end else if (out_take) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb565_gray_sequencer.sv
// Self-checking bench for rgb565_gray_sequencer: directed spec scenarios plus
// randomized traffic checked against a byte-queue reference model.
module tb_rgb565_gray_sequencer;

  localparam int unsigned DEPTH = 2;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic [31:0] inData;
  logic        inReady;
  logic        outValid;
  logic [31:0] outData;
  logic        outReady;
  logic        busy;
`ifdef GRAY_FLUSH_EN
  logic        flush;
`endif

  int          n_vec;
  int          n_err;
  logic [7:0]  byte_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] last_out;

  rgb565_gray_sequencer #(.INPUT_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .outValid (outValid),
    .outData  (outData),
    .outReady (outReady),
    .busy     (busy)
`ifdef GRAY_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Luma of one RGB565 pixel from plain arithmetic
  function automatic logic [7:0] gray(input logic [15:0] p);
    int r, g, b, yy;
    r  = (int'(p) / 2048) % 32;
    g  = (int'(p) / 32) % 64;
    b  = int'(p) % 32;
    yy = ((r * 8) * 54 + (g * 4) * 183 + (b * 8) * 19) / 256;
    return 8'(yy % 256);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: each accepted word yields two bytes; every four bytes form a word
  task automatic model_push(input logic [31:0] w);
    byte_q.push_back(gray(w[15:0]));
    byte_q.push_back(gray(w[31:16]));
    while (byte_q.size() >= 4) begin
      exp_q.push_back({byte_q[3], byte_q[2], byte_q[1], byte_q[0]});
      repeat (4) void'(byte_q.pop_front());
    end
  endtask

  // One clock: drive, observe handshakes, advance, score
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, output logic took);
    logic        ti, to, pv;
    logic [31:0] seen;
    inValid  = iv;
    inData   = id;
    outReady = ordy;
    #1;
    ti   = inValid && inReady;
    to   = outValid && outReady;
    pv   = outValid;
    seen = outData;
    @(posedge clock);
    #1;
    if (ti) model_push(id);
    if (to) begin
      check_eq("out_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("out_data", seen, exp_q.pop_front());
      last_out = seen;
    end
    if (pv && !ordy) begin
      check_eq("hold_valid", 32'(outValid), 32'd1);
      check_eq("hold_data", outData, seen);
    end
    took = ti;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic t;
    repeat (n) cycle(1'b0, 32'h0, ordy, t);
  endtask

  // Offer queued words; mode 0: outReady low, 1: high, 2: toggling
  task automatic feed(input int ncyc, input int mode);
    logic        t, iv, ordy;
    logic [31:0] d;
    for (int i = 0; i < ncyc; i++) begin
      ordy = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'(i % 2);
      iv   = (pend.size() != 0);
      d    = iv ? pend[0] : $urandom;
      cycle(iv, d, ordy, t);
      if (t) void'(pend.pop_front());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || outValid); i++) idle(1, 1'b1);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    inValid  = 1'b1;
    inData   = $urandom;
    outReady = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    inValid = 1'b0;
    byte_q.delete();
    exp_q.delete();
    pend.delete();
    check_eq("rst_outValid", 32'(outValid), 32'd0);
    check_eq("rst_outData", outData, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_inReady", 32'(inReady), 32'd1);
  endtask

  initial begin
    logic t;
    n_vec    = 0;
    n_err    = 0;
    last_out = 32'hdeadbeef;
    reset    = 1'b1;
    inValid  = 1'b0;
    inData   = 32'h0;
    outReady = 1'b0;
`ifdef GRAY_FLUSH_EN
    flush    = 1'b0;
`endif
    @(posedge clock);
    #1;
    do_reset();

    // Known pair with latency: valid exactly after the fourth edge
    cycle(1'b1, 32'h07E0F800, 1'b1, t);
    cycle(1'b1, 32'h001FFFFF, 1'b1, t);
    idle(2, 1'b0);
    check_eq("lat_not_yet", 32'(outValid), 32'd0);
    idle(1, 1'b0);
    check_eq("lat_valid", 32'(outValid), 32'd1);
    check_eq("pair_word", outData, 32'h12FAB434);
    idle(1, 1'b1);
    idle(4, 1'b1);
    check_eq("single_out", 32'(outValid), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // All-black and all-white extremes
    pend = '{32'h0, 32'h0};
    feed(12, 1);
    check_eq("black_word", last_out, 32'h0);
    pend = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    feed(12, 1);
    check_eq("white_word", last_out, 32'hFAFAFAFA);

    // Backpressure: output holds, FIFO fills, nothing lost
    for (int i = 0; i < 6; i++) pend.push_back($urandom);
    feed(30, 0);
    check_eq("bp_full", 32'(inReady), 32'd0);
    check_eq("bp_valid", 32'(outValid), 32'd1);
    feed(40, 1);
    check_eq("bp_pend_empty", 32'(pend.size()), 32'd0);
    drain();

    // Reset after three converted pixels discards the partial word
    do_reset();
    cycle(1'b1, $urandom, 1'b1, t);
    cycle(1'b1, $urandom, 1'b1, t);
    idle(2, 1'b1);
    do_reset();
    pend = '{$urandom, $urandom};
    feed(12, 1);
    drain();

`ifdef GRAY_FLUSH_EN
    // Flush a half-filled word from idle
    do_reset();
    pend = '{32'h07E0F800};
    feed(6, 1);
    flush = 1'b1;
    exp_q.push_back({16'h0, byte_q[1], byte_q[0]});
    byte_q.delete();
    idle(1, 1'b1);
    flush = 1'b0;
    idle(3, 1'b1);
    check_eq("flush_word", last_out, 32'h0000B434);
    check_eq("flush_busy", 32'(busy), 32'd0);
`endif

    // Random traffic with outReady toggling every cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'(i % 2), t);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
